audio_frame_scheduler: RTL and testbench
========================================

// Module: audio_frame_scheduler
// PURPOSE
//  Sequences the I2S DAC output path: divides clk into audio_mclk/audio_lrck/audio_sck,
//  accepts stereo samples from an upstream source over a valid/ready handshake,
//  and hands one stereo pair per LRCK frame to the parallel-to-serial shifter.
//  Sits between the tone/sample generators and the serializer, which consumes
//  audio_left/audio_right on the negedge of audio_sck.
// PARAMETERS
//  MCLK_BIT   1   divider-counter bit driving audio_mclk (clk/4)
//  SCK_BIT    3   divider-counter bit driving audio_sck (clk/16)
//  LRCK_BIT   8   divider-counter bit driving audio_lrck (clk/512); counter width = LRCK_BIT+1
//  MUTE_UR    1   1: output 16'd0 on underrun; 0: repeat last pair
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  en            in   1   playback enable
//  in_valid      in   1   upstream sample pair valid
//  in_ready      out  1   scheduler can take a pair this cycle
//  in_left       in   16  upstream left sample (two's complement)
//  in_right      in   16  upstream right sample
//  audio_left    out  16  active left sample to serializer
//  audio_right   out  16  active right sample to serializer
//  audio_mclk    out  1   master clock to DAC
//  audio_lrck    out  1   word-select clock to DAC
//  audio_sck     out  1   serial bit clock to DAC / serializer
//  frame_tick    out  1   1-cycle pulse: frame boundary, active pair updated next cycle
//  running       out  1   high in PRIME, RUN, STOP
//  underrun_cnt  out  16  saturating count of frames with no pending pair
//  underrun_clr  in   1   synchronous clear of underrun_cnt
// BEHAVIOUR
//  Reset: state=IDLE, divider=0, pending empty, all outputs 0 (in_ready=0).
//  Divider: free-running up counter cnt[LRCK_BIT:0] in PRIME/RUN/STOP; held 0 in IDLE.
//   audio_mclk=cnt[MCLK_BIT], audio_sck=cnt[SCK_BIT], audio_lrck=cnt[LRCK_BIT], all registered.
//   frame_tick=1 in the cycle cnt==all-ones (wrap to 0 next cycle); never in IDLE.
//  Pending buffer: one entry (pend_l, pend_r, pend_v).
//   in_ready = (state!=IDLE && state!=STOP) && (!pend_v || frame_tick).
//   Accept when in_valid&&in_ready: pend <= in pair, pend_v <= 1.
//   Accept and frame_tick in same cycle: old pending goes to active, new pair becomes pending.
//  Frame update (on frame_tick, visible the next cycle):
//   pend_v: active <= pend, pend_v <= 0 (unless refilled same cycle).
//   !pend_v in RUN: underrun; active <= 0 if MUTE_UR else unchanged; underrun_cnt+1, saturate 16'hFFFF.
//   underrun_clr wins over increment in same cycle (count -> 0).
//  FSM:
//   IDLE : en=1 -> PRIME (divider starts at 0 next cycle).
//   PRIME: active held 0, no underrun counting; frame_tick && pend_v -> RUN (pair loaded);
//          en=0 -> IDLE immediately.
//   RUN  : en=0 -> STOP.
//   STOP : in_ready=0; completes current frame; at frame_tick -> IDLE, active <= 0,
//          pending discarded; en re-asserted in STOP has no effect until IDLE.
//  IDLE: audio_* clocks 0, active 0, pend_v cleared; underrun_cnt retained.
//  Async reset mid-frame: all state, counter and outputs return to reset values immediately.
// TESTING
//  Reset then en=1, no input -> clocks start, audio_left/right=0, underrun_cnt stays 0 in PRIME.
//  en=1, push 16'h1234/16'hABCD before first tick -> after tick state RUN, outputs 1234/ABCD;
//   audio_sck period 16 clk, audio_lrck period 512 clk, frame_tick every 512 clk.
//  In RUN, withhold input 3 frames, MUTE_UR=1 -> outputs 0, underrun_cnt=3; clr -> 0.
//  Hold pending full, assert in_valid with 16'h5555 on frame_tick cycle -> accepted,
//   old pair active, 5555 active one frame later; no pair lost.
//  Deassert en mid-frame at cnt=100 -> clocks continue until cnt wraps, then IDLE, all 0.
//  Pull rst_n low at cnt=300 in RUN -> all outputs 0 that cycle, state IDLE after release.

Source files
------------

// File: rtl/audio_frame_scheduler.sv
// I2S output sequencer: divides clk into MCLK/SCK/LRCK and holds a one-deep stereo pending slot.
// Active pair changes the cycle after frame_tick; in_ready drops while the slot is full, except on the tick.
module audio_frame_scheduler #(
  parameter int MCLK_BIT = 1,
  parameter int SCK_BIT  = 3,
  parameter int LRCK_BIT = 8,
  parameter bit MUTE_UR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        frame_tick,
  output logic        running,
  output logic [15:0] underrun_cnt,
  input  logic        underrun_clr
);

  localparam int CW = LRCK_BIT + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [15:0]   act_l_q, act_l_d, act_r_q, act_r_d;
  logic [15:0]   ur_q, ur_d;
  logic          pend_v_q, pend_v_d;
  logic          accept;

  assign frame_tick = (state_q != IDLE) && (&cnt_q);
  // The tick frees the slot, so a new pair can land in the same cycle the old one goes active.
  assign in_ready   = ((state_q == PRIME) || (state_q == RUN)) && (!pend_v_q || frame_tick);
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    pend_v_d = pend_v_q;
    act_l_d  = act_l_q;
    act_r_d  = act_r_q;
    ur_d     = ur_q;

    if (accept) begin
      pend_l_d = in_left;
      pend_r_d = in_right;
      pend_v_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        pend_v_d = 1'b0;
        act_l_d  = '0;
        act_r_d  = '0;
        if (en) state_d = PRIME;
      end
      PRIME: begin
        if (!en) begin
          state_d  = IDLE;
          cnt_d    = '0;
          pend_v_d = 1'b0;
          act_l_d  = '0;
          act_r_d  = '0;
        end else if (frame_tick && pend_v_q) begin
          act_l_d = pend_l_q;
          act_r_d = pend_r_q;
          if (!accept) pend_v_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_tick) begin
          if (pend_v_q) begin
            act_l_d = pend_l_q;
            act_r_d = pend_r_q;
            if (!accept) pend_v_d = 1'b0;
          end else begin
            if (MUTE_UR) begin
              act_l_d = '0;
              act_r_d = '0;
            end
            if (ur_q != 16'hFFFF) ur_d = ur_q + 16'd1;
          end
        end
        if (!en) state_d = STOP;
      end
      STOP: begin
        // Counter wraps to zero on its own at the tick, so IDLE starts clean.
        if (frame_tick) begin
          state_d  = IDLE;
          pend_v_d = 1'b0;
          act_l_d  = '0;
          act_r_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (underrun_clr) ur_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      pend_v_q <= 1'b0;
      act_l_q  <= '0;
      act_r_q  <= '0;
      ur_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      pend_v_q <= pend_v_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
      ur_q     <= ur_d;
    end
  end

  assign audio_left   = act_l_q;
  assign audio_right  = act_r_q;
  assign audio_mclk   = cnt_q[MCLK_BIT];
  assign audio_sck    = cnt_q[SCK_BIT];
  assign audio_lrck   = cnt_q[LRCK_BIT];
  assign running      = (state_q != IDLE);
  assign underrun_cnt = ur_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Bench for audio_frame_scheduler: frame-level reference model, per-cycle compare, directed and random stimulus.
module tb_audio_frame_scheduler;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0, underrun_clr = 1'b0;
  logic [15:0] in_left = '0, in_right = '0;
  logic        in_ready, audio_mclk, audio_lrck, audio_sck, frame_tick, running;
  logic [15:0] audio_left, audio_right, underrun_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_frame_scheduler #(
    .MCLK_BIT(1), .SCK_BIT(3), .LRCK_BIT(8), .MUTE_UR(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .audio_left(audio_left), .audio_right(audio_right),
    .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_sck(audio_sck),
    .frame_tick(frame_tick), .running(running),
    .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 prime, 2 run, 3 stop; phase is cycles into the current frame.
  int          m_mode = 0, m_phase = 0, m_ur = 0, cyc = 0;
  logic [31:0] m_act = '0;
  logic [31:0] pq[$];

  function automatic logic m_tick();
    return (m_mode != 0) && (m_phase == 511);
  endfunction

  function automatic logic m_rdy();
    return ((m_mode == 1) || (m_mode == 2)) && ((pq.size() == 0) || m_tick());
  endfunction

  function automatic logic m_bit(input int b);
    return 1'((m_phase >> b) & 1);
  endfunction

  initial forever begin : model
    logic tk, acc, had;
    int   m0;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_ur = 0; m_act = '0;
      pq.delete();
    end else begin
      cyc++;
      tk  = m_tick();
      acc = in_valid && m_rdy();
      had = (pq.size() > 0);
      m0  = m_mode;
      if (m0 == 0) begin
        pq.delete(); m_act = '0; m_phase = 0;
        if (en) m_mode = 1;
      end else if ((m0 == 1 && !en) || (m0 == 3 && tk)) begin
        m_mode = 0; m_phase = 0; m_act = '0;
        pq.delete();
      end else begin
        if (tk && had) begin
          m_act = pq.pop_front();
          if (m0 == 1) m_mode = 2;
        end else if (tk && m0 == 2) begin
          m_act = '0;
          if (m_ur < 65535) m_ur++;
        end
        if (m0 == 2 && !en) m_mode = 3;
        if (acc) pq.push_back({in_left, in_right});
        m_phase = (m_phase + 1) % 512;
      end
      if (underrun_clr) m_ur = 0;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    chk("audio_left",   32'(audio_left),   32'(m_act[31:16]));
    chk("audio_right",  32'(audio_right),  32'(m_act[15:0]));
    chk("audio_mclk",   32'(audio_mclk),   32'(m_bit(1)));
    chk("audio_sck",    32'(audio_sck),    32'(m_bit(3)));
    chk("audio_lrck",   32'(audio_lrck),   32'(m_bit(8)));
    chk("frame_tick",   32'(frame_tick),   32'(m_tick()));
    chk("in_ready",     32'(in_ready),     32'(m_rdy()));
    chk("running",      32'(running),      32'(m_mode != 0));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ur));
  end

  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_tick !== 1'b1 && k < 2000);
    if (frame_tick !== 1'b1) chk("tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? audio_sck : audio_lrck;
  endfunction

  task automatic period(input int sel, output int p);
    logic prev, cur;
    int   k = 0, t0 = -1;
    p    = -1;
    prev = sig(sel);
    while (k < 1500 && p < 0) begin
      @(negedge clk);
      k++;
      cur = sig(sel);
      if (cur && !prev) begin
        if (t0 < 0) t0 = k;
        else p = k - t0;
      end
      prev = cur;
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_left = l; in_right = r; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic goto_run();
    int k = 0;
    en = 1'b1;
    while (m_mode != 2 && k < 3000) begin
      in_valid = 1'b1; in_left = 16'($urandom); in_right = 16'($urandom);
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    if (m_mode != 2) chk("goto_run_timeout", 32'(running), 32'd2);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (m_phase != ph && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (m_phase != ph) chk("phase_timeout", 32'(m_phase), 32'(ph));
  endtask

  initial begin : main
    int          t1, t2, p, n;
    logic [15:0] l1, r1, l2, r2;
    #23;
    chk("rst_running",  32'(running),      32'd0);
    chk("rst_in_ready", 32'(in_ready),     32'd0);
    chk("rst_left",     32'(audio_left),   32'd0);
    chk("rst_sck",      32'(audio_sck),    32'd0);
    chk("rst_lrck",     32'(audio_lrck),   32'd0);
    chk("rst_ur",       32'(underrun_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    period(0, p);
    chk("sck_period", 32'(p), 32'd16);
    wait_tick(); t1 = cyc;
    wait_tick(); t2 = cyc;
    chk("tick_period", 32'(t2 - t1), 32'd512);
    period(1, p);
    chk("lrck_period", 32'(p), 32'd512);
    chk("prime_ur",   32'(underrun_cnt), 32'd0);
    chk("prime_left", 32'(audio_left),   32'd0);

    push(16'h1234, 16'hABCD);
    wait_tick();
    @(negedge clk);
    chk("first_left",  32'(audio_left),  32'h1234);
    chk("first_right", 32'(audio_right), 32'hABCD);

    repeat (3) wait_tick();
    @(negedge clk);
    chk("underrun3",  32'(underrun_cnt), 32'd3);
    chk("mute_left",  32'(audio_left),   32'd0);
    chk("mute_right", 32'(audio_right),  32'd0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_cleared", 32'(underrun_cnt), 32'd0);

    l1 = 16'($urandom); r1 = 16'($urandom);
    l2 = 16'($urandom); r2 = 16'($urandom);
    push(l1, r1);
    wait_tick();
    @(negedge clk);
    chk("p1_left", 32'(audio_left), 32'(l1));
    push(l2, r2);
    wait_tick();
    chk("rdy_on_tick", 32'(in_ready), 32'd1);
    in_left = 16'h5555; in_right = 16'h5555; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("p2_left",  32'(audio_left),  32'(l2));
    chk("p2_right", 32'(audio_right), 32'(r2));
    wait_tick();
    @(negedge clk);
    chk("p5555_left",  32'(audio_left),  32'h5555);
    chk("p5555_right", 32'(audio_right), 32'h5555);

    for (int i = 0; i < 4000; i++) begin
      in_valid     = ($urandom_range(0, 199) == 0);
      in_left      = 16'($urandom);
      in_right     = 16'($urandom);
      underrun_clr = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 699) == 0) en = ~en;
      @(negedge clk);
    end
    in_valid = 1'b0; underrun_clr = 1'b0;

    goto_run();
    wait_phase(100);
    en = 1'b0;
    n  = 0;
    while (running === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 100) en = 1'b1;
    end
    chk("stop_latency", 32'(n), 32'd412);
    chk("stop_left",    32'(audio_left), 32'd0);
    chk("stop_mclk",    32'(audio_mclk), 32'd0);
    chk("stop_sck",     32'(audio_sck),  32'd0);
    chk("stop_lrck",    32'(audio_lrck), 32'd0);

    goto_run();
    wait_phase(300);
    chk("sck_before_rst", 32'(audio_sck), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_running",  32'(running),      32'd0);
    chk("arst_left",     32'(audio_left),   32'd0);
    chk("arst_right",    32'(audio_right),  32'd0);
    chk("arst_sck",      32'(audio_sck),    32'd0);
    chk("arst_lrck",     32'(audio_lrck),   32'd0);
    chk("arst_in_ready", 32'(in_ready),     32'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(running), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
